rr_decode_arbiter: RTL

Round-robin arbiter that shares one 8-way select resource among 8 requesters. It picks one requester and holds the grant until the owner signals done, drops its request, or exceeds a hold limit. It presents the grant both as a 3-bit index and as a one-hot select vector. The one-hot vector comes from an internal 3-to-8 one-hot decoder and drives the shared resource's enables.

---
 rtl/rr_decode_arbiter_pkg.sv | 28 ++
 rtl/rr_decode_arbiter_if.sv | 24 ++
 rtl/rr_decode_arbiter_dec3to8_onehot.sv | 13 +
 rtl/rr_decode_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types, constants and the round-robin scan helper for the
// 8-way decode arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set index at or after ptr, wrapping mod N_REQ. Scanning from
  // the far end lets the closest hit overwrite the earlier ones.
  function automatic logic [IDX_W-1:0] next_rr_index(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] idx;
    next_rr_index = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) next_rr_index = idx;
    end
  endfunction

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the
// arbiter (slave).
interface rr_decode_arbiter_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant_onehot;
  logic             timeout;
  logic [CNT_W-1:0] busy_cnt;

  modport master (
    output req, done,
    input  grant_valid, grant_idx, grant_onehot, timeout, busy_cnt
  );

  modport slave (
    input  req, done,
    output grant_valid, grant_idx, grant_onehot, timeout, busy_cnt
  );

endinterface

// File: rtl/rr_decode_arbiter_dec3to8_onehot.sv
// 3-to-8 one-hot decoder with enable; drives the shared resource's
// enables from the registered grant.
module dec3to8_onehot
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] in,
  input  logic             enable,
  output logic [N_REQ-1:0] out
);

  assign out = enable ? (N_REQ'(1) << in) : '0;

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters: holds a grant until done,
// request withdrawal, or the hold limit, then re-arbitrates in IDLE.
module rr_decode_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_decode_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q,       state_d;
  logic [IDX_W-1:0] ptr_q,         ptr_d;
  logic [IDX_W-1:0] grant_idx_q,   grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic [CNT_W-1:0] busy_cnt_q,    busy_cnt_d;
  logic             timeout_q,     timeout_d;

  logic rel_done, rel_drop, rel_hold;

  assign rel_done = bus.done;
  assign rel_drop = ~bus.req[grant_idx_q];
  assign rel_hold = (busy_cnt_q == HOLD_LAST);

  always_comb begin
    // NOTE: every _d takes its held value first so no path leaves it
    // unassigned; that is what keeps this block free of latches.
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    busy_cnt_d    = busy_cnt_q;
    timeout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_idx_d   = next_rr_index(bus.req, ptr_q);
          grant_valid_d = 1'b1;
          busy_cnt_d    = '0;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          grant_valid_d = 1'b0;
          busy_cnt_d    = '0;
          ptr_d         = grant_idx_q + IDX_W'(1);
          state_d       = IDLE;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_d     = rel_hold && !rel_done && !rel_drop;
        end else begin
          busy_cnt_d    = busy_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
        busy_cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      busy_cnt_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      busy_cnt_q    <= busy_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.timeout     = timeout_q;
  assign bus.busy_cnt    = busy_cnt_q;

  dec3to8_onehot u_dec (
    .in     (grant_idx_q),
    .enable (grant_valid_q),
    .out    (bus.grant_onehot)
  );

endmodule
